// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter_if: fetch, data and memory-side signals of mem_port_arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              stall_if;
  logic              stall_mem;
  logic              err_timeout;
  logic              err_spurious;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err_timeout, err_spurious
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err_timeout, err_spurious
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter: shares one single-ported memory between IF and DM stages.
// Define ARB_ROUND_ROBIN_EN for round-robin instead of DM-priority.  Rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input wire clk,
  input wire reset,
  mem_port_arbiter_if.slave bus
);
  localparam int            WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              pick_dm;
  logic              grant_dm;
  logic              grant_if;
  logic              done_ok;
  logic              done_to;
  logic              in_if;
  logic              in_busy;
  logic [ADDR_W-1:0] grant_addr;
  logic [WD_W-1:0]   wdog;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dm <= 1'b0;
    end else if (grant_dm | grant_if) begin
      last_dm <= grant_dm;
    end
  end

  // On contention the requester not served last wins.
  assign pick_dm = bus.dm_req & (~bus.if_req | ~last_dm);
`else
  assign pick_dm = bus.dm_req;
`endif

  assign in_if      = (state == BUSY_IF);
  assign in_busy    = (state == BUSY_IF) | (state == BUSY_DM);
  assign grant_addr = grant_dm ? bus.dm_addr : bus.if_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_dm) begin
          grant_dm   = 1'b1;
          state_next = BUSY_DM;
        end else if (bus.if_req) begin
          grant_if   = 1'b1;
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_valid) begin
          done_ok    = 1'b1;
          state_next = DONE;
        end else if (wdog == WD_LAST) begin
          done_to    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.if_rdata     <= '0;
      bus.if_ready     <= 1'b0;
      bus.dm_rdata     <= '0;
      bus.dm_ready     <= 1'b0;
      bus.mem_en       <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.err_timeout  <= 1'b0;
      bus.err_spurious <= 1'b0;
      wdog             <= '0;
    end else begin
      bus.mem_en   <= grant_dm | grant_if;
      bus.if_ready <= (done_ok | done_to) & in_if;
      bus.dm_ready <= (done_ok | done_to) & ~in_if;

      // Address and write data stay put after issue so the memory may sample late.
      if (grant_dm | grant_if) begin
        bus.mem_addr <= grant_addr;
        bus.mem_we   <= grant_dm & bus.dm_we;
        if (grant_dm) begin
          bus.mem_wdata <= bus.dm_wdata;
        end
      end

      if (in_busy & ~done_ok & ~done_to) begin
        wdog <= wdog + 1'b1;
      end else begin
        wdog <= '0;
      end

      if (done_ok & in_if) begin
        bus.if_rdata <= bus.mem_rdata;
      end
      if (done_ok & ~in_if & ~bus.mem_we) begin
        bus.dm_rdata <= bus.mem_rdata;
      end

      if (done_to) begin
        bus.err_timeout <= 1'b1;
        if (in_if) begin
          bus.if_rdata <= {DATA_W{1'b1}};
        end else begin
          bus.dm_rdata <= {DATA_W{1'b1}};
        end
      end

      if (bus.mem_valid & ((state == IDLE) | (state == DONE))) begin
        bus.err_spurious <= 1'b1;
      end
    end
  end

  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = bus.dm_req & ~bus.dm_ready;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter: random IF/DM traffic against a memory model and scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int NO_RESP = 99;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  int          if_delay_q[$];
  int          dm_delay_q[$];
  logic [31:0] ref_mem   [logic [29:0]];
  logic [31:0] mem_store [logic [29:0]];
  logic [31:0] last_dm_rdata = '0;
  logic        any_timeout   = 1'b0;
  logic [29:0] cur_if_addr   = '0;
  logic [29:0] cur_dm_addr   = '0;
  logic        cur_dm_we     = 1'b0;
  logic [31:0] cur_dm_wdata  = '0;
  logic        g_if = 1'b0, g_dm = 1'b0, rr_last_dm = 1'b0;
  logic        prev_if_ready = 1'b0, prev_dm_ready = 1'b0, prev_mem_en = 1'b0;
  int          spur_cnt = 0, spur_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a[15:0], a[29:14]} ^ 32'hC3A5_1E0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_read(input logic [29:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction

  function automatic int pick_delay();
    return ($urandom_range(0, 7) == 0) ? NO_RESP : int'($urandom_range(0, TIMEOUT - 1));
  endfunction

  // Waits for the requester's ready pulse; returns clock edges from request to pulse.
  task automatic wait_ready(input bit is_if, output int edges);
    int  n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    do begin
      @(negedge clk);
      n++;
      rdy = is_if ? bus.if_ready : bus.dm_ready;
      if (n == 1) check(is_if ? "stall_if_pending" : "stall_mem_pending",
                        is_if ? bus.stall_if : bus.stall_mem, 1);
    end while (!rdy && n < 400);
    check(is_if ? "if_ready_seen" : "dm_ready_seen", rdy, 1);
    edges = n - 1;
    @(posedge clk);
    #1;
  endtask

  task automatic if_txn(input logic [29:0] a, input int d, output int edges);
    logic [31:0] e;
    if (d >= TIMEOUT) begin
      e = '1;
      any_timeout = 1'b1;
    end else begin
      e = ref_read(a);
    end
    exp_if_q.push_back(e);
    if_delay_q.push_back(d);
    cur_if_addr = a;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    wait_ready(1'b1, edges);
    bus.if_req  = 1'b0;
  endtask

  task automatic dm_txn(input logic [29:0] a, input logic we, input logic [31:0] wd,
                        input int d, output int edges);
    logic [31:0] e;
    if (d >= TIMEOUT) begin
      e = '1;
      any_timeout = 1'b1;
    end else if (we) begin
      e = last_dm_rdata;
      ref_mem[a] = wd;
    end else begin
      e = ref_read(a);
    end
    last_dm_rdata = e;
    exp_dm_q.push_back(e);
    dm_delay_q.push_back(d);
    cur_dm_addr  = a;
    cur_dm_we    = we;
    cur_dm_wdata = wd;
    bus.dm_addr  = a;
    bus.dm_we    = we;
    bus.dm_wdata = wd;
    bus.dm_req   = 1'b1;
    wait_ready(1'b0, edges);
    bus.dm_req   = 1'b0;
  endtask

  // Request levels at the edge that issued the current mem_en.
  always @(posedge clk) begin
    g_if <= bus.if_req;
    g_dm <= bus.dm_req;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.if_ready) begin
      if (exp_if_q.size() == 0) check("if_ready_unexpected", bus.if_ready, 0);
      else check("if_rdata", bus.if_rdata, exp_if_q.pop_front());
      check("stall_if_at_ready", bus.stall_if, 0);
      check("if_ready_width", prev_if_ready, 0);
    end
    if (bus.dm_ready) begin
      if (exp_dm_q.size() == 0) check("dm_ready_unexpected", bus.dm_ready, 0);
      else check("dm_rdata", bus.dm_rdata, exp_dm_q.pop_front());
      check("stall_mem_at_ready", bus.stall_mem, 0);
      check("dm_ready_width", prev_dm_ready, 0);
    end
    if (bus.mem_en) check("mem_en_width", prev_mem_en, 0);
    prev_if_ready <= bus.if_ready;
    prev_dm_ready <= bus.dm_ready;
    prev_mem_en   <= bus.mem_en;
  end

  // Memory model: checks each issue against the expected grantee and answers after its delay.
  initial begin : responder
    bit          to_dm;
    int          d;
    logic [29:0] a;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) rr_last_dm = 1'b0;
      if (spur_cnt != spur_done) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        spur_done++;
      end else if (bus.mem_en) begin
`ifdef ARB_ROUND_ROBIN_EN
        to_dm = g_dm && (!g_if || !rr_last_dm);
`else
        to_dm = g_dm;
`endif
        rr_last_dm = to_dm;
        if (to_dm) begin
          check("grant_dm_addr", bus.mem_addr, cur_dm_addr);
          check("grant_dm_we", bus.mem_we, cur_dm_we);
          if (cur_dm_we) check("grant_dm_wdata", bus.mem_wdata, cur_dm_wdata);
          d = (dm_delay_q.size() != 0) ? dm_delay_q.pop_front() : NO_RESP;
        end else begin
          check("grant_if_addr", bus.mem_addr, cur_if_addr);
          check("grant_if_we", bus.mem_we, 0);
          d = (if_delay_q.size() != 0) ? if_delay_q.pop_front() : NO_RESP;
        end
        if (d < TIMEOUT) begin
          repeat (d) @(negedge clk);
          a = bus.mem_addr;
          if (bus.mem_we) mem_store[a] = bus.mem_wdata;
          bus.mem_rdata = bus.mem_we ? 32'h0BAD_F00D : mem_read(a);
          bus.mem_valid = 1'b1;
          @(negedge clk);
          bus.mem_valid = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_if_ready"},     bus.if_ready, 0);
    check({tag, "_dm_ready"},     bus.dm_ready, 0);
    check({tag, "_if_rdata"},     bus.if_rdata, 0);
    check({tag, "_dm_rdata"},     bus.dm_rdata, 0);
    check({tag, "_mem_en"},       bus.mem_en, 0);
    check({tag, "_mem_we"},       bus.mem_we, 0);
    check({tag, "_mem_addr"},     bus.mem_addr, 0);
    check({tag, "_mem_wdata"},    bus.mem_wdata, 0);
    check({tag, "_err_timeout"},  bus.err_timeout, 0);
    check({tag, "_err_spurious"}, bus.err_spurious, 0);
  endtask

  initial begin : stimulus
    int e1, e2;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed fetch with one-cycle memory latency.
    mem_store[30'h0100000] = 32'h8C08_0000;
    ref_mem[30'h0100000]   = 32'h8C08_0000;
    if_txn(30'h0100000, 1, e1);
    check("if_min_latency_edges", e1, 3);

    // Directed write: dm_rdata must keep its previous value.
    dm_txn(30'h4004000, 1'b1, 32'h0000_002A, 1, e1);
    check("dm_write_stored", mem_read(30'h4004000), 32'h0000_002A);

    // Two contended rounds; grant order is checked at each issue.
    for (int r = 0; r < 2; r++) begin
      fork
        dm_txn(30'h4000010 + 30'(r), 1'b0, 32'h0, 1, e1);
        if_txn(30'h0000020 + 30'(r), 2, e2);
      join
    end

    // Random concurrent traffic.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int ei;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          if_txn(30'($urandom_range(0, 4095)), pick_delay(), ei);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          int ej;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          dm_txn(30'h4000000 | 30'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 $urandom, pick_delay(), ej);
        end
      end
    join
    check("err_timeout_vs_model", bus.err_timeout, any_timeout);

    // Watchdog abort on a fetch that the memory never answers.
    if_txn(30'h0000300, NO_RESP, e1);
    check("timeout_latency_edges", e1, 5);
    repeat (3) @(posedge clk);
    #1;
    check("err_timeout_sticky", bus.err_timeout, 1);

    // Spurious completion while idle.
    check("err_spurious_before", bus.err_spurious, 0);
    spur_cnt++;
    repeat (4) @(posedge clk);
    #1;
    check("err_spurious_set", bus.err_spurious, 1);

    // Reset in the middle of a data read that is never answered.
    dm_delay_q.push_back(NO_RESP);
    cur_dm_addr = 30'h4000005;
    cur_dm_we   = 1'b0;
    bus.dm_addr = 30'h4000005;
    bus.dm_we   = 1'b0;
    bus.dm_req  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_access_mem_addr", bus.mem_addr, 30'h4000005);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    bus.dm_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_err_spurious", bus.err_spurious, 0);
    spur_cnt++;
    repeat (4) @(posedge clk);
    #1;
    check("late_valid_err_spurious", bus.err_spurious, 1);
    check("late_valid_err_timeout", bus.err_timeout, 0);

    check("if_queue_drained", exp_if_q.size(), 0);
    check("dm_queue_drained", exp_dm_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : time_limit
    #2000000;
    $display("FAIL global_time_limit: got no end expected end by 2000000");
    $fatal(1, "time limit");
  end
endmodule
`default_nettype wire
